// File: rtl/font_rom_arbiter.sv
// ---------------------------------------------------------------------------
// font_rom_arbiter
//
// Shares one synchronous font ROM among NREQ text-overlay requesters
// (score, logo, rule text, game-over banner). One requester is picked per
// cycle and its address is driven to the ROM. The returned glyph row is
// handed back three cycles after the request cycle, together with a
// one-hot tag naming its owner.
//
// Configuration macro:
//   FONT_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                           undefined -> round-robin (default)
//
// Ports:
//   clk       system clock (same domain as the vga_sync pixel tick)
//   reset     synchronous, active-high reset
//   req       [NREQ]     per-requester read request, level
//   addr      [NREQ*AW]  packed addresses, requester i at addr[i*AW +: AW]
//   gnt       [NREQ]     one-hot grant pulse, registered
//   rom_addr  [AW]       address to the font ROM, registered
//   rom_data  [DW]       font ROM output, valid one cycle after rom_addr
//   rd_valid  [NREQ]     one-hot owner tag for rd_data, registered
//   rd_data   [DW]       registered font row
// ---------------------------------------------------------------------------
module font_rom_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 11,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic [NREQ-1:0]   rd_valid,
  output logic [DW-1:0]     rd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [NREQ-1:0] gnt_reg, tag1_reg, tag2_reg, rd_valid_reg;
  logic [AW-1:0]   rom_addr_reg;
  logic [DW-1:0]   rd_data_reg;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [AW-1:0]   win_addr;

  // Unpacked view of the packed address bus.
  logic [AW-1:0] addr_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = addr[gi*AW +: AW];
    end
  endgenerate

  // Search req starting at ptr and wrapping; the first set bit wins.
  // In fixed-priority mode ptr never leaves 0, so the same search gives
  // lowest-index-wins.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    if (win_found) win_onehot[win_idx] = 1'b1;
    win_addr = addr_arr[win_idx];
  end

`ifdef FONT_ARB_FIXED_PRIO_EN
  assign ptr_next = '0;
`else
  // Pointer moves just past the winner; it holds when nobody requested.
  always_comb begin
    ptr_next = ptr_reg;
    if (win_found) begin
      if (win_idx == PW'(NREQ - 1)) ptr_next = '0;
      else                          ptr_next = win_idx + PW'(1);
    end
  end
`endif

  // Pipeline: request cycle C -> gnt/rom_addr/tag1 (C+1) -> tag2 (C+2),
  // ROM data valid in C+2 -> rd_valid/rd_data (C+3).
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      tag1_reg     <= '0;
      tag2_reg     <= '0;
      rd_valid_reg <= '0;
      rom_addr_reg <= '0;
      rd_data_reg  <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      gnt_reg      <= win_onehot;
      tag1_reg     <= win_onehot;
      tag2_reg     <= tag1_reg;
      rd_valid_reg <= tag2_reg;
      if (win_found) rom_addr_reg <= win_addr;
      // Only capture ROM data that belongs to a granted read, so rd_data
      // stays put between valid pulses.
      if (|tag2_reg) rd_data_reg <= rom_data;
    end
  end

  assign gnt      = gnt_reg;
  assign rom_addr = rom_addr_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed testbench for font_rom_arbiter with a synchronous ROM model.
module tb_font_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 11;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic [NREQ-1:0]   rd_valid;
  logic [DW-1:0]     rd_data;

  int tests = 0;
  int fails = 0;

  font_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (a == 11'h2A3) return 8'h3C;
    return a[7:0] ^ 8'h5A;
  endfunction

  // Synchronous font ROM: data one cycle after address.
  always_ff @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  logic [NREQ-1:0] exp_g [10];
  logic [AW-1:0]   av [NREQ];

  initial begin
    reset = 1'b1;
    req   = '0;
    addr  = '0;

    // 1. Reset held 2 cycles with all requests high.
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rdv", 32'(rd_valid), 32'h0);
      chk("rst_rdd", 32'(rd_data), 32'h0);
      chk("rst_radr", 32'(rom_addr), 32'h0);
    end
    reset = 1'b0;
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    tick();
    chk("rst_first_rdv", 32'(rd_valid), 32'b0001);
    chk("rst_first_rdd", 32'(rd_data), 32'(rom_fn(11'h000)));

    // 2. Single request from requester 2.
    set_addr(2, 11'h2A3);
    req = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_radr", 32'(rom_addr), 32'h2A3);
    req = '0;
    tick();
    chk("single_gnt_pulse", 32'(gnt), 32'h0);
    tick();
    chk("single_rdv", 32'(rd_valid), 32'b0100);
    chk("single_rdd", 32'(rd_data), 32'h3C);
    tick();
    chk("single_rdv_drop", 32'(rd_valid), 32'h0);
    chk("single_rdd_hold", 32'(rd_data), 32'h3C);

`ifndef FONT_ARB_FIXED_PRIO_EN
    // 4. ptr=3 now; requester 3 idle must be skipped with wrap to 0.
    set_addr(0, 11'h111);
    set_addr(1, 11'h222);
    req = 4'b0011;
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'b0001);
    chk("wrap_radr0", 32'(rom_addr), 32'h111);
    tick();
    chk("wrap_gnt1", 32'(gnt), 32'b0010);
    chk("wrap_radr1", 32'(rom_addr), 32'h222);
    tick();
    chk("wrap_gnt2", 32'(gnt), 32'b0001);
    req = '0;
    for (int c = 0; c < 3; c++) tick();
`else
    // 6. Fixed priority: requester 0 starves requester 1.
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("fixed_gnt", 32'(gnt), 32'b0001);
    end
    req = 4'b0010;
    tick();
    chk("fixed_gnt_r1", 32'(gnt), 32'b0010);
    req = '0;
    for (int c = 0; c < 3; c++) tick();
`endif

    // 5. Reset mid-flight discards in-flight reads.
    req = 4'b0011;
    tick();
    tick();
    chk("mid_gnt_before", 32'($countones(gnt)), 32'd1);
    reset = 1'b1;
    req   = '0;
    tick();
    chk("mid_rdv_c3", 32'(rd_valid), 32'h0);
    chk("mid_gnt_c3", 32'(gnt), 32'h0);
    chk("mid_rdd_clr", 32'(rd_data), 32'h0);
    tick();
    chk("mid_rdv_c4", 32'(rd_valid), 32'h0);
    reset = 1'b0;
    req   = 4'b1001;
    tick();
    chk("mid_after_gnt", 32'(gnt), 32'b0001);
    req = '0;
    for (int c = 0; c < 3; c++) tick();

`ifndef FONT_ARB_FIXED_PRIO_EN
    // 3. Full contention from ptr=0 for 8 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      av[i] = AW'(11'h040 + 11'h105 * i);
      set_addr(i, av[i]);
    end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g[k] = 4'b0001 << (k % 4);
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
      chk($sformatf("rr_radr%0d", k), 32'(rom_addr), 32'(av[k % 4]));
      if (k >= 2) begin
        chk($sformatf("rr_rdv%0d", k), 32'(rd_valid), 32'(exp_g[k-2]));
        chk($sformatf("rr_rdd%0d", k), 32'(rd_data), 32'(rom_fn(av[(k-2) % 4])));
      end
    end
    req = '0;
    for (int k = 8; k < 10; k++) begin
      tick();
      chk($sformatf("rr_rdv%0d", k), 32'(rd_valid), 32'(exp_g[k-2]));
      chk($sformatf("rr_rdd%0d", k), 32'(rd_data), 32'(rom_fn(av[(k-2) % 4])));
    end
    tick();
    chk("rr_rdv_idle", 32'(rd_valid), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
Shares one synchronous font ROM among up to NREQ text-overlay requesters: score, logo, rule text and game-over banner.
- Each requester presents an 11-bit font address: char code[6:0] concatenated with row[3:0].
- The block picks one requester per cycle with round-robin arbitration and drives the ROM address.
- It returns the 8-bit font row to the winner with a one-hot valid tag.
- Sits between the text generators and the single font_rom instance, in the clk domain that also carries the vga_sync pixel tick.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 11, font ROM address width
DW, 8, font ROM data width (one glyph row)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester read request, level
addr  input  NREQ*AW  packed addresses; requester i uses addr[i*AW +: AW]
gnt  output  NREQ  one-hot grant pulse, registered
rom_addr  output  AW  address to font ROM, registered
rom_data  input  DW  font ROM output, valid one cycle after rom_addr
rd_valid  output  NREQ  one-hot tag marking rd_data's owner, registered
rd_data  output  DW  registered font row

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset. All state updates occur on the rising edge of clk.
- Reset values: gnt=0, rd_valid=0, rd_data=0, rom_addr=0, round-robin pointer ptr=0, internal tag pipe=0.
- Arbitration is combinational within cycle C:
  - Winner is the first i with req[i]=1, searching i = ptr, ptr+1, ... and wrapping modulo NREQ.
  - If no req bit is set, there is no winner.
- End of cycle C with a winner w:
  - gnt <= onehot(w)
  - rom_addr <= addr[w]
  - tag1 <= onehot(w)
  - ptr <= (w+1) mod NREQ
- End of cycle C with no winner:
  - gnt <= 0, tag1 <= 0
  - rom_addr holds its value
  - ptr holds its value
- Cycle C+1: gnt is high for exactly one cycle; the ROM samples rom_addr.
- End of cycle C+1: tag2 <= tag1.
- End of cycle C+2: rd_data <= rom_data and rd_valid <= tag2.
- Latency: request cycle C to rd_valid/rd_data in cycle C+3. This is fixed and independent of contention.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants to different requesters are allowed on consecutive cycles.
- Handshake rules:
  - A requester holds req and addr stable until it sees gnt. addr is sampled only in the request cycle.
  - req still high in the cycle gnt is visible counts as a new request.
  - A requester that keeps req high continuously with no competitor is granted on every cycle.
- Fairness: with all NREQ requesters continuously active, each is granted exactly once in every NREQ consecutive grants. The maximum wait for a held request is NREQ cycles.
- ptr wrap: after a win by requester NREQ-1, ptr=0.
- Simultaneous events: a request rising in the same cycle the pointer passes it is still served in rotation order, with no lost requests.
- Reset mid-operation:
  - All in-flight reads are discarded; rd_valid and gnt are 0 from the first edge with reset=1.
  - ptr returns to 0.
  - Requests seen during reset are ignored.
- rd_valid never has more than one bit set.
- rd_data is unchanged while rd_valid=0, except when reset clears it.

Optional Feature:
Macro FONT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest index wins. ptr is removed or held at 0. A continuously asserting requester 0 starves all others. Latency and pipeline are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset: hold reset 2 cycles with req=4'b1111 -> gnt=0, rd_valid=0, rd_data=0, rom_addr=0 throughout; first grant after release goes to requester 0.
2. Single request: req=4'b0100 for one cycle C, addr[2]=11'h2A3, ROM model returns 8'h3C for 11'h2A3 -> gnt=4'b0100 at C+1, rom_addr=11'h2A3 at C+1, rd_valid=4'b0100 and rd_data=8'h3C at C+3.
3. Full contention: req=4'b1111 held 8 cycles starting with ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000, with rd_valid repeating the same sequence 2 cycles later.
4. Wrap and skip: ptr=3 after a grant to requester 2, then req=4'b0011 -> grants 0001, 0010, 0001; requester 3 idle is skipped.
5. Reset mid-flight: grants issued in cycles C and C+1, reset asserted at C+2 -> no rd_valid pulse at C+3 or C+4; after release, req=4'b1000 and req=4'b0001 together yield first grant 0001.
6. With FONT_ARB_FIXED_PRIO_EN defined: req=4'b0011 held 4 cycles -> gnt=0001 every cycle and requester 1 is never granted; drop req[0] -> gnt=0010 next cycle.
